memory_stage: RTL and testbench

- Memory-access stage directly downstream of execute in the 64-bit LEGv8 datapath.
- Consumes the execute outputs: zero flag, ALU result used as the address, store data, and branch target.
- Resolves branch selection (PCSrc) and runs a req/ack handshake to a variable-latency data memory.
- Stalls upstream stages while an access is outstanding; flags misaligned and timed-out accesses.

---
 rtl/memory_stage.sv | 164 ++++++++++++++++
 tb/tb_memory_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//   Memory-access stage of the 64-bit LEGv8 pipeline, directly after execute.
//   Resolves the CBZ branch (PCSrc_M) combinationally and drives a req/ack
//   handshake to a variable-latency data memory. Upstream stages are stalled
//   while an access is outstanding. Misaligned and timed-out accesses set a
//   sticky fault flag that only reset clears.
//
//   Ports
//     clk, reset        : clock, synchronous active-high reset
//     Branch_M          : CBZ in this stage
//     MemRead_M         : LDUR in this stage
//     MemWrite_M        : STUR in this stage (wins if MemRead_M is also set)
//     zero_M            : ALU zero flag
//     aluResult_M       : effective address
//     writeData_M       : store data
//     PCBranch_M        : branch target
//     dm_ack, dm_rdata  : memory completion strobe and load data
//     PCSrc_M           : take-branch select
//     PCBranch_out      : branch target pass-through
//     dm_req, dm_we     : memory request and direction
//     dm_addr, dm_wdata : request address/data, captured at request start
//     readData_M        : last completed load data
//     stall_M           : hold upstream stages and PC
//     mem_fault         : sticky misaligned/timeout flag
// ---------------------------------------------------------------------------
module memory_stage #(
   parameter int N       = 64,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         Branch_M,
   input  logic         MemRead_M,
   input  logic         MemWrite_M,
   input  logic         zero_M,
   input  logic [N-1:0] aluResult_M,
   input  logic [N-1:0] writeData_M,
   input  logic [N-1:0] PCBranch_M,
   input  logic         dm_ack,
   input  logic [N-1:0] dm_rdata,
   output logic         PCSrc_M,
   output logic [N-1:0] PCBranch_out,
   output logic         dm_req,
   output logic         dm_we,
   output logic [N-1:0] dm_addr,
   output logic [N-1:0] dm_wdata,
   output logic [N-1:0] readData_M,
   output logic         stall_M,
   output logic         mem_fault
);

   // Counter wide enough to hold TIMEOUT itself
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t         state_r;
   logic [CW-1:0]  cnt_r;
   logic           dm_req_r;
   logic           dm_we_r;
   logic [N-1:0]   dm_addr_r;
   logic [N-1:0]   dm_wdata_r;
   logic [N-1:0]   read_data_r;
   logic           mem_fault_r;
   logic           memop_s;
   logic           aligned_s;
   logic           stall_s;

   assign memop_s   = MemRead_M | MemWrite_M;
   assign aligned_s = (aluResult_M[2:0] == 3'b000);

   // Branch resolution is independent of the memory handshake
   assign PCSrc_M      = Branch_M & zero_M;
   assign PCBranch_out = PCBranch_M;

   assign dm_req     = dm_req_r;
   assign dm_we      = dm_we_r;
   assign dm_addr    = dm_addr_r;
   assign dm_wdata   = dm_wdata_r;
   assign readData_M = read_data_r;
   assign mem_fault  = mem_fault_r;
   assign stall_M    = stall_s;

   // Stall: in IDLE a pending memory op must be held; REQ always holds
   always_comb begin
      stall_s = 1'b0;
      case (state_r)
         S_IDLE:  stall_s = memop_s;
         S_REQ:   stall_s = 1'b1;
         S_DONE:  stall_s = 1'b0;
         default: stall_s = 1'b0;
      endcase
   end

   // Access FSM with registered handshake outputs and result/fault state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= S_IDLE;
         cnt_r       <= {CW{1'b0}};
         dm_req_r    <= 1'b0;
         dm_we_r     <= 1'b0;
         dm_addr_r   <= {N{1'b0}};
         dm_wdata_r  <= {N{1'b0}};
         read_data_r <= {N{1'b0}};
         mem_fault_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (memop_s && aligned_s) begin
                  state_r    <= S_REQ;
                  dm_req_r   <= 1'b1;
                  dm_addr_r  <= aluResult_M;
                  dm_wdata_r <= writeData_M;
                  dm_we_r    <= MemWrite_M;
                  cnt_r      <= {CW{1'b0}};
               end else if (memop_s) begin
                  // Misaligned: never reaches memory, completes immediately
                  state_r     <= S_DONE;
                  mem_fault_r <= 1'b1;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_REQ: begin
               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               // Ack is checked first so an ack on the last cycle is not a fault
               if (dm_ack) begin
                  state_r  <= S_DONE;
                  dm_req_r <= 1'b0;
                  if (!dm_we_r) begin
                     read_data_r <= dm_rdata;
                  end else begin
                     read_data_r <= read_data_r;
                  end
               end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                  state_r     <= S_DONE;
                  dm_req_r    <= 1'b0;
                  mem_fault_r <= 1'b1;
                  if (!dm_we_r) begin
                     read_data_r <= {N{1'b0}};
                  end else begin
                     read_data_r <= read_data_r;
                  end
               end else begin
                  state_r <= S_REQ;
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
            end
            default: begin
               state_r  <= S_IDLE;
               dm_req_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
//   Directed bench for memory_stage. A transaction-level model inside the
//   stimulus task predicts, cycle by cycle, what each output must be for a
//   given instruction and ack timing; a single negedge process compares the
//   DUT against those predictions. Literal checks after key operations pin
//   the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_memory_stage;

   localparam int N       = 64;
   localparam int TIMEOUT = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         Branch_M, MemRead_M, MemWrite_M, zero_M;
   logic [N-1:0] aluResult_M, writeData_M, PCBranch_M;
   logic         dm_ack;
   logic [N-1:0] dm_rdata;
   logic         PCSrc_M, dm_req, dm_we, stall_M, mem_fault;
   logic [N-1:0] PCBranch_out, dm_addr, dm_wdata, readData_M;

   // Model expectations for the current cycle
   logic         chk_en;
   logic         exp_stall, exp_req, exp_we, exp_fault;
   logic [N-1:0] exp_addr, exp_wdata, exp_rdata;

   int n_compared   = 0;
   int n_mismatched = 0;
   int stall_cnt    = 0;

   memory_stage #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .Branch_M     (Branch_M),
      .MemRead_M    (MemRead_M),
      .MemWrite_M   (MemWrite_M),
      .zero_M       (zero_M),
      .aluResult_M  (aluResult_M),
      .writeData_M  (writeData_M),
      .PCBranch_M   (PCBranch_M),
      .dm_ack       (dm_ack),
      .dm_rdata     (dm_rdata),
      .PCSrc_M      (PCSrc_M),
      .PCBranch_out (PCBranch_out),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .readData_M   (readData_M),
      .stall_M      (stall_M),
      .mem_fault    (mem_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the rising edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("pcsrc", {63'd0, PCSrc_M}, {63'd0, Branch_M & zero_M});
         check("pcbranch", PCBranch_out, PCBranch_M);
         check("stall", {63'd0, stall_M}, {63'd0, exp_stall});
         check("dm_req", {63'd0, dm_req}, {63'd0, exp_req});
         check("fault", {63'd0, mem_fault}, {63'd0, exp_fault});
         check("rdata", readData_M, exp_rdata);
         if (exp_req) begin
            check("dm_we", {63'd0, dm_we}, {63'd0, exp_we});
            check("dm_addr", dm_addr, exp_addr);
            check("dm_wdata", dm_wdata, exp_wdata);
         end
         if (stall_M) stall_cnt++;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One instruction through the stage. ack_at is the REQ cycle (1-based)
   // in which memory acks; 0 or beyond TIMEOUT means memory never answers.
   task automatic do_op(input logic rd, input logic wr, input logic [N-1:0] addr,
                        input logic [N-1:0] wdata, input int ack_at, input logic [N-1:0] rdata);
      logic memop;
      logic timed_out;
      int   wlen;
      memop       = rd | wr;
      MemRead_M   = rd;
      MemWrite_M  = wr;
      aluResult_M = addr;
      writeData_M = wdata;
      // Stray ack while idle must be ignored
      dm_ack      = 1'b1;
      dm_rdata    = 64'h0BAD_0BAD_0BAD_0BAD;
      exp_stall   = memop;
      exp_req     = 1'b0;
      next_cycle();
      if (memop) begin
         if (addr[2:0] != 3'b000) begin
            exp_fault = 1'b1;
            exp_stall = 1'b0;
            next_cycle();
         end else begin
            timed_out = (ack_at <= 0) || (ack_at > TIMEOUT);
            wlen      = timed_out ? TIMEOUT : ack_at;
            exp_req   = 1'b1;
            exp_stall = 1'b1;
            exp_we    = wr;
            exp_addr  = addr;
            exp_wdata = wdata;
            dm_rdata  = rdata;
            for (int i = 1; i <= wlen; i++) begin
               dm_ack = (i == ack_at);
               next_cycle();
            end
            exp_req   = 1'b0;
            exp_stall = 1'b0;
            if (timed_out) begin
               exp_fault = 1'b1;
               if (!wr) exp_rdata = 64'd0;
            end else if (!wr) begin
               exp_rdata = rdata;
            end
            // Stray ack in the completion cycle must be ignored
            dm_ack   = 1'b1;
            dm_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
            next_cycle();
         end
      end
      MemRead_M  = 1'b0;
      MemWrite_M = 1'b0;
      dm_ack     = 1'b0;
      exp_stall  = 1'b0;
   endtask

   task automatic model_reset();
      exp_stall = 1'b0;
      exp_req   = 1'b0;
      exp_we    = 1'b0;
      exp_fault = 1'b0;
      exp_addr  = 64'd0;
      exp_wdata = 64'd0;
      exp_rdata = 64'd0;
   endtask

   initial begin
      chk_en      = 1'b0;
      reset       = 1'b1;
      Branch_M    = 1'b0;
      MemRead_M   = 1'b0;
      MemWrite_M  = 1'b0;
      zero_M      = 1'b0;
      aluResult_M = 64'd0;
      writeData_M = 64'd0;
      PCBranch_M  = 64'd0;
      dm_ack      = 1'b0;
      dm_rdata    = 64'd0;
      model_reset();
      next_cycle();
      // Reset state observed while reset is still asserted
      chk_en = 1'b1;
      next_cycle();
      reset = 1'b0;
      check("reset_rdata", readData_M, 64'd0);

      // Branch taken, no memory activity
      Branch_M   = 1'b1;
      zero_M     = 1'b1;
      PCBranch_M = 64'd5;
      stall_cnt  = 0;
      do_op(1'b0, 1'b0, 64'd0, 64'd0, 0, 64'd0);
      check("br_pcsrc_lit", {63'd0, PCSrc_M}, 64'd1);
      check("br_target_lit", PCBranch_out, 64'd5);
      check("br_nostall_lit", 64'(stall_cnt), 64'd0);
      zero_M = 1'b0;
      do_op(1'b0, 1'b0, 64'd0, 64'd0, 0, 64'd0);
      check("br_nottaken_lit", {63'd0, PCSrc_M}, 64'd0);
      Branch_M = 1'b0;

      // Load with ack in first REQ cycle
      stall_cnt = 0;
      do_op(1'b1, 1'b0, 64'h10, 64'd0, 1, 64'hDEAD);
      check("ld1_rdata_lit", readData_M, 64'hDEAD);
      check("ld1_stall_lit", 64'(stall_cnt), 64'd2);

      // Store with 3 wait cycles
      stall_cnt = 0;
      do_op(1'b0, 1'b1, 64'h18, 64'd7, 4, 64'h1111);
      check("st_stall_lit", 64'(stall_cnt), 64'd5);
      check("st_rdata_lit", readData_M, 64'hDEAD);
      check("st_fault_lit", {63'd0, mem_fault}, 64'd0);

      // Ack on the final allowed cycle: no fault
      stall_cnt = 0;
      do_op(1'b1, 1'b0, 64'h28, 64'd0, TIMEOUT, 64'hBEEF);
      check("late_ack_fault_lit", {63'd0, mem_fault}, 64'd0);
      check("late_ack_rdata_lit", readData_M, 64'hBEEF);
      check("late_ack_stall_lit", 64'(stall_cnt), 64'd17);

      // Read and write together behaves as a write
      do_op(1'b1, 1'b1, 64'h30, 64'h55, 2, 64'h1234);
      check("rw_rdata_lit", readData_M, 64'hBEEF);

      // Timeout
      stall_cnt = 0;
      do_op(1'b1, 1'b0, 64'h20, 64'd0, 0, 64'h9999);
      check("to_fault_lit", {63'd0, mem_fault}, 64'd1);
      check("to_rdata_lit", readData_M, 64'd0);
      check("to_stall_lit", 64'(stall_cnt), 64'd17);

      // Fault is sticky across a good access
      do_op(1'b1, 1'b0, 64'h8, 64'd0, 3, 64'hCAFE);
      check("sticky_fault_lit", {63'd0, mem_fault}, 64'd1);
      check("sticky_rdata_lit", readData_M, 64'hCAFE);

      // Clean reset, then misaligned load
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      model_reset();
      stall_cnt = 0;
      do_op(1'b1, 1'b0, 64'h13, 64'd0, 1, 64'h4444);
      check("mis_fault_lit", {63'd0, mem_fault}, 64'd1);
      check("mis_stall_lit", 64'(stall_cnt), 64'd1);
      check("mis_rdata_lit", readData_M, 64'd0);

      // Good load so the reset below has something to clear
      do_op(1'b1, 1'b0, 64'h50, 64'd0, 2, 64'h777);

      // Reset during the 2nd REQ cycle
      MemRead_M   = 1'b1;
      aluResult_M = 64'h40;
      dm_ack      = 1'b0;
      exp_stall   = 1'b1;
      next_cycle();
      exp_req  = 1'b1;
      exp_we   = 1'b0;
      exp_addr = 64'h40;
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset      = 1'b0;
      MemRead_M  = 1'b0;
      model_reset();
      dm_ack     = 1'b1;
      dm_rdata   = 64'h5A5A;
      next_cycle();
      check("rst_req_lit", {63'd0, dm_req}, 64'd0);
      check("rst_rdata_lit", readData_M, 64'd0);
      check("rst_fault_lit", {63'd0, mem_fault}, 64'd0);
      dm_ack = 1'b0;
      next_cycle();
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
